// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss request, memory read and cache array write signals of the fill FSM
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  fsm_busy;
  logic                  memory_enable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  write_data_array;
  logic [OFF_W-1:0]      cache_word_offset;
  logic [15:0]           cache_data;
  logic                  write_tag_array;
  logic                  fill_done;

  // master is the fill FSM; slave is the surrounding cache pipeline and memory
  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_enable, memory_address, write_data_array,
           cache_word_offset, cache_data, write_tag_array, fill_done
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_enable, memory_address, write_data_array,
           cache_word_offset, cache_data, write_tag_array, fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache block fill FSM; CACHE_FILL_PERF_COUNT_EN adds a saturating fill_count
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
`ifdef CACHE_FILL_PERF_COUNT_EN
  ,
  output logic [15:0]      fill_count
`endif
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0]      issue_count;
  logic [CNT_W-1:0]      recv_count;
  logic                  issuing;
  logic                  accept;
  logic                  last_word;
  logic                  start_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      base        <= '0;
      issue_count <= '0;
      recv_count  <= '0;
    end else begin
      state <= state_nxt;
      if (start_fill) begin
        base        <= bus.miss_address & ~BLOCK_MASK;
        issue_count <= '0;
        recv_count  <= '0;
      end else begin
        if (issuing) issue_count <= issue_count + 1'b1;
        if (accept)  recv_count  <= recv_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    start_fill = 1'b0;
    issuing    = 1'b0;
    accept     = 1'b0;
    last_word  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) begin
          start_fill = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        issuing   = (issue_count != FULL_CNT);
        accept    = bus.memory_data_valid;
        last_word = accept && (recv_count == LAST_CNT);
        if (last_word) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // the masked base leaves room for 2*issue_count, so an OR-free add never carries out of the block
  assign bus.fsm_busy          = (state == FILL);
  assign bus.memory_enable     = issuing;
  assign bus.memory_address    = issuing ? (base + ADDR_WIDTH'({issue_count, 1'b0})) : '0;
  assign bus.write_data_array  = accept;
  assign bus.cache_word_offset = recv_count[OFF_W-1:0];
  assign bus.cache_data        = bus.memory_data;
  assign bus.write_tag_array   = last_word;
  assign bus.fill_done         = last_word;

`ifdef CACHE_FILL_PERF_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_count <= '0;
    end else if (last_word && (fill_count != 16'hFFFF)) begin
      fill_count <= fill_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cache_fill_fsm_if #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) bus ();

`ifdef CACHE_FILL_PERF_COUNT_EN
  logic [15:0] fill_count;
  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fill_count(fill_count)
  );
`else
  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first FILL cycle; valid on every (gap+1)-th cycle; returns in the following cycle.
  task automatic fill_block(input logic [15:0] base, input int gap, input string nm);
    int   k;
    int   cyc;
    bit   done_seen;
    logic v;
    k = 0;
    cyc = 1;
    done_seen = 0;
    while (!done_seen && cyc < 60) begin
      v = ((cyc - 1) % (gap + 1)) == 0;
      bus.memory_data_valid = v;
      bus.memory_data = v ? (base + 16'h0101 * 16'(k)) : 16'hDEAD;
      #1;
      check_eq({nm, " busy"}, 32'(bus.fsm_busy), 32'd1);
      check_eq({nm, " en"}, 32'(bus.memory_enable), 32'(cyc <= 8));
      if (cyc <= 8) check_eq({nm, " addr"}, 32'(bus.memory_address), 32'(base + 16'(2 * (cyc - 1))));
      check_eq({nm, " wr"}, 32'(bus.write_data_array), 32'(v));
      if (v) begin
        check_eq({nm, " off"}, 32'(bus.cache_word_offset), 32'(k));
        check_eq({nm, " data"}, 32'(bus.cache_data), 32'(base + 16'h0101 * 16'(k)));
      end
      check_eq({nm, " done"}, 32'(bus.fill_done), 32'(v && k == 7));
      check_eq({nm, " tag"}, 32'(bus.write_tag_array), 32'(v && k == 7));
      if (v && k == 7) done_seen = 1;
      if (v) k++;
      tick();
      cyc++;
    end
    bus.memory_data_valid = 1'b0;
    check_eq({nm, " completed"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    int tags;
    logic v;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.miss_detected = 1'b0;
    bus.miss_address = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = '0;
    #2;
    check_eq("rst busy", 32'(bus.fsm_busy), 32'd0);
    check_eq("rst en", 32'(bus.memory_enable), 32'd0);
    check_eq("rst addr", 32'(bus.memory_address), 32'd0);
    check_eq("rst wr", 32'(bus.write_data_array), 32'd0);
    check_eq("rst tag", 32'(bus.write_tag_array), 32'd0);
    check_eq("rst done", 32'(bus.fill_done), 32'd0);
`ifdef CACHE_FILL_PERF_COUNT_EN
    check_eq("rst fill_count", 32'(fill_count), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();

    // miss at 0x1236, latency 4, plus a miss pulse at 0x2000 mid-fill
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h1236;
    #1;
    check_eq("t1 idle busy", 32'(bus.fsm_busy), 32'd0);
    tick();
    tags = 0;
    for (int c = 1; c <= 13; c++) begin
      bus.miss_detected = (c == 3);
      bus.miss_address = (c == 3) ? 16'h2000 : 16'h1236;
      v = (c >= 5 && c <= 12);
      bus.memory_data_valid = v;
      bus.memory_data = 16'hA000 + 16'(c);
      #1;
      check_eq("t1 busy", 32'(bus.fsm_busy), 32'(c <= 12));
      check_eq("t1 en", 32'(bus.memory_enable), 32'(c <= 8));
      if (c <= 8) check_eq("t1 addr", 32'(bus.memory_address), 32'(16'h1230 + 16'(2 * (c - 1))));
      check_eq("t1 wr", 32'(bus.write_data_array), 32'(v));
      if (v) begin
        check_eq("t1 off", 32'(bus.cache_word_offset), 32'(c - 5));
        check_eq("t1 data", 32'(bus.cache_data), 32'(16'hA000 + 16'(c)));
      end
      check_eq("t1 tag", 32'(bus.write_tag_array), 32'(c == 12));
      check_eq("t1 done", 32'(bus.fill_done), 32'(c == 12));
      if (bus.write_tag_array) tags++;
      tick();
    end
    bus.memory_data_valid = 1'b0;
    check_eq("t1 tag writes", 32'(tags), 32'd1);

    // gapped returns 1,0,0,1,...
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h400A;
    tick();
    bus.miss_detected = 1'b0;
    fill_block(16'h4000, 2, "gap");
    #1;
    check_eq("gap idle busy", 32'(bus.fsm_busy), 32'd0);

    // reset after three returns, then a stray valid
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h5004;
    tick();
    bus.miss_detected = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data = 16'h5500 + 16'(c);
      tick();
    end
    bus.memory_data_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_eq("arst busy", 32'(bus.fsm_busy), 32'd0);
    check_eq("arst en", 32'(bus.memory_enable), 32'd0);
    check_eq("arst addr", 32'(bus.memory_address), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    bus.memory_data_valid = 1'b1;
    #1;
    check_eq("stray wr", 32'(bus.write_data_array), 32'd0);
    check_eq("stray tag", 32'(bus.write_tag_array), 32'd0);
    check_eq("stray done", 32'(bus.fill_done), 32'd0);
    check_eq("stray busy", 32'(bus.fsm_busy), 32'd0);
    tick();
    bus.memory_data_valid = 1'b0;
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h0010;
    tick();
    bus.miss_detected = 1'b0;
    fill_block(16'h0010, 0, "post");

    // miss held high across completion: IDLE for one cycle, then a new fill
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h6000;
    tick();
    fill_block(16'h6000, 0, "b2b1");
    bus.miss_address = 16'h6100;
    #1;
    check_eq("b2b idle busy", 32'(bus.fsm_busy), 32'd0);
    tick();
    bus.miss_detected = 1'b0;
    #1;
    check_eq("b2b restart en", 32'(bus.memory_enable), 32'd1);
    check_eq("b2b restart addr", 32'(bus.memory_address), 32'h6100);
    fill_block(16'h6100, 0, "b2b2");
`ifdef CACHE_FILL_PERF_COUNT_EN
    #1;
    check_eq("fill_count", 32'(fill_count), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, byte-address width of miss and memory addresses.
REQ-002 Parameter BLOCK_WORDS, default 8, 16-bit words per cache block; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-005 miss_detected  input  1  cache miss request, sampled only in IDLE.
REQ-006 miss_address  input  ADDR_WIDTH  byte address of the missing access.
REQ-007 fsm_busy  output  1  high in FILL; upstream pipeline stalls on it.
REQ-008 memory_enable  output  1  read request to the memory for the address on memory_address.
REQ-009 memory_address  output  ADDR_WIDTH  word-aligned byte address of the current request.
REQ-010 memory_data_valid  input  1  memory returns one word this cycle; requests are answered in order.
REQ-011 memory_data  input  16  returned word, meaningful only when memory_data_valid is high.
REQ-012 write_data_array  output  1  write strobe to the cache data array.
REQ-013 cache_word_offset  output  log2(BLOCK_WORDS)  word index within the block for the write.
REQ-014 cache_data  output  16  word to write; equals memory_data in the same cycle.
REQ-015 write_tag_array  output  1  one-cycle tag/valid write strobe at fill completion.
REQ-016 fill_done  output  1  one-cycle completion pulse, coincident with write_tag_array.

Function
REQ-017 States: IDLE and FILL; encoding is free.
REQ-018 IDLE with miss_detected high: on that edge, latch base = miss_address with its low log2(BLOCK_WORDS)+1 bits cleared; clear both counters; go to FILL.
REQ-019 FILL issue phase: memory_enable high for exactly BLOCK_WORDS consecutive cycles, starting the first cycle in FILL.
REQ-020 Issue address = base + 2*issue_count; issue_count increments each issue cycle and stops at BLOCK_WORDS.
REQ-021 Return phase, overlapped with issue: each cycle with memory_data_valid high drives write_data_array=1, cache_word_offset=recv_count and cache_data=memory_data, all combinationally; recv_count then increments.
REQ-022 Return of word BLOCK_WORDS-1: write_tag_array and fill_done pulse in that same cycle; next state IDLE.
REQ-023 fsm_busy = (state == FILL), including the completion cycle.
REQ-024 In IDLE, memory_data_valid is ignored; no strobes are asserted.
REQ-025 miss_detected is ignored in FILL; a miss still high in the cycle after completion starts a new fill.
REQ-026 No address carry beyond the block: base alignment guarantees the addresses stay inside the block.
REQ-027 Return latency is unconstrained; the FSM waits indefinitely in FILL for outstanding words.

Reset
REQ-028 rst low, asynchronously: state=IDLE; counters and base=0; fsm_busy, memory_enable, write_data_array, write_tag_array, fill_done=0; memory_address=0.
REQ-029 Reset mid-fill abandons the fill without a tag write; returns arriving after reset release are ignored.

Configuration
REQ-030 Macro CACHE_FILL_PERF_COUNT_EN defined: adds output fill_count (16 bits), reset to 0, incremented on each fill_done pulse, saturating at 16'hFFFF.
REQ-031 Macro undefined: no fill_count port and no counter logic; all other behaviour is identical.

Verification
REQ-032 Miss at 16'h1236 with memory latency 4 -> requests at 0x1230, 0x1232, ... 0x123E on cycles 1-8; writes at offsets 0-7 on cycles 5-12; tag write and fill_done on cycle 12; IDLE on cycle 13.
REQ-033 miss_detected pulsed again at 0x2000 during a fill -> ignored; exactly one tag write, for block 0x1230.
REQ-034 Returns with gaps (valid pattern 1,0,0,1,...) -> offsets 0..7 written in order, each equal to the returned data; fill_done only after the 8th valid.
REQ-035 rst pulled low after 3 returns, then a stray valid after release -> no strobes; fsm_busy low; next miss at 0x0010 fills offsets 0-7 from base 0x0010.
REQ-036 miss_detected held high across completion -> second fill starts the cycle after fill_done; with CACHE_FILL_PERF_COUNT_EN, fill_count reads 2 after both fills complete.
